// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the pipelined multiplier: field widths, rounding
// modes, operand classes, and classification / leading-zero helper functions.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [31:0] QNAN = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } op_class_e;

  typedef enum logic [1:0] {
    KIND_FINITE = 2'd0,
    KIND_NAN    = 2'd1,
    KIND_INF    = 2'd2,
    KIND_ZERO   = 2'd3
  } res_kind_e;

  function automatic op_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    op_class_e c;
    if (e == {EXP_W{1'b1}}) begin
      c = (m == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
    end else if (e == {EXP_W{1'b0}}) begin
`ifdef FPMUL_FTZ_EN
      c = CLS_ZERO;
`else
      c = (m == {MAN_W{1'b0}}) ? CLS_ZERO : CLS_SUB;
`endif
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

  // Position of the highest set bit counted from bit 47; callers guarantee v != 0.
  function automatic logic [5:0] lzc48(input logic [47:0] v);
    logic [5:0] n;
    n = 6'd47;
    for (int i = 0; i < 48; i++) begin
      n = v[i] ? 6'(47 - i) : n;
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_round_norm.sv
// Second-stage datapath: normalise the raw significand product, denormalise tiny
// results with sticky collection, round, and produce the final word plus flags.
module fp32_round_norm
  import fp32_pkg::*;
(
  input  res_kind_e         i_kind,
  input  logic              i_sign,
  input  logic [47:0]       i_prod,
  input  logic signed [9:0] i_exp,
  input  rm_e               i_rm,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MAN_W-1:0]  o_man,
  output logic              o_invalid,
  output logic              o_overflow,
  output logic              o_underflow,
  output logic              o_inexact,
  output logic              o_zero
);

  logic [5:0]        w_lz;
  logic [5:0]        w_sh;
  logic [47:0]       w_norm;
  logic [47:0]       w_mask;
  logic [47:0]       w_shifted;
  logic signed [9:0] w_exp_n;
  logic signed [9:0] w_sh_full;
  logic signed [9:0] w_exp_b;
  logic signed [9:0] w_exp_r;
  logic              w_tiny;
  logic              w_lost;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic              w_carry;
  logic              w_hidden;
  logic              w_ovf;
  logic              w_ovf_inf;
  logic [23:0]       w_sig;
  logic [24:0]       w_sig_r;
  logic [MAN_W-1:0]  w_man_r;

  // w_norm has its leading one at bit 47; w_exp_n is the matching biased exponent.
  assign w_lz      = lzc48(i_prod);
  assign w_norm    = i_prod << w_lz;
  assign w_exp_n   = i_exp + 10'sd1 - $signed({4'b0000, w_lz});
  assign w_tiny    = (w_exp_n < 10'sd1);
  assign w_sh_full = 10'sd1 - w_exp_n;

  // Denormalising shift distance, saturated once every bit is already sticky.
  always_comb begin
    w_sh = 6'd0;
    if (!w_tiny) begin
      w_sh = 6'd0;
    end else if (w_sh_full > 10'sd48) begin
      w_sh = 6'd48;
    end else begin
      w_sh = w_sh_full[5:0];
    end
  end

  // Bits pushed below the significand by the denormalising shift.
  always_comb begin
    w_mask = 48'd0;
    if (w_sh == 6'd48) begin
      w_mask = {48{1'b1}};
    end else begin
      w_mask = (48'd1 << w_sh) - 48'd1;
    end
  end

  assign w_shifted = w_norm >> w_sh;
  assign w_lost    = |(w_norm & w_mask);
  assign w_exp_b   = w_tiny ? 10'sd1 : w_exp_n;
  assign w_sig     = w_shifted[47:24];
  assign w_guard   = w_shifted[23];
  assign w_sticky  = (|w_shifted[22:0]) | w_lost;

  // Round-increment decision for the selected mode.
  always_comb begin
    w_inc = 1'b0;
    case (i_rm)
      RM_RNE:  w_inc = w_guard & (w_sticky | w_sig[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = ~i_sign & (w_guard | w_sticky);
      RM_RDN:  w_inc = i_sign & (w_guard | w_sticky);
      default: w_inc = 1'b0;
    endcase
  end

  // A carry out of 24 bits renormalises; a subnormal reaching bit 23 becomes min-normal.
  assign w_sig_r   = {1'b0, w_sig} + {24'd0, w_inc};
  assign w_carry   = w_sig_r[24];
  assign w_exp_r   = w_exp_b + $signed({9'd0, w_carry});
  assign w_man_r   = w_carry ? w_sig_r[23:1] : w_sig_r[22:0];
  assign w_hidden  = w_carry | w_sig_r[23];
  assign w_ovf     = (w_exp_r >= 10'sd255);
  assign w_ovf_inf = (i_rm == RM_RNE) | ((i_rm == RM_RUP) & ~i_sign) | ((i_rm == RM_RDN) & i_sign);

  // Final word and flag selection, specials first.
  always_comb begin
    o_sign      = i_sign;
    o_exp       = {EXP_W{1'b0}};
    o_man       = {MAN_W{1'b0}};
    o_invalid   = 1'b0;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_inexact   = 1'b0;
    o_zero      = 1'b0;
    case (i_kind)
      KIND_NAN: begin
        {o_sign, o_exp, o_man} = QNAN;
        o_invalid = 1'b1;
      end
      KIND_INF: begin
        o_exp      = {EXP_W{1'b1}};
        o_overflow = 1'b1;
      end
      KIND_ZERO: begin
        o_zero = 1'b1;
      end
      KIND_FINITE: begin
        if (w_ovf) begin
          o_overflow = 1'b1;
          o_inexact  = 1'b1;
          if (w_ovf_inf) begin
            o_exp = {EXP_W{1'b1}};
          end else begin
            o_exp = 8'hFE;
            o_man = {MAN_W{1'b1}};
          end
        end else begin
          o_inexact = w_guard | w_sticky;
          o_man     = w_man_r;
          o_exp     = w_hidden ? w_exp_r[7:0] : 8'd0;
          if (w_hidden) begin
            o_zero = 1'b0;
          end else if (w_man_r == {MAN_W{1'b0}}) begin
            o_zero = 1'b1;
          end else begin
`ifdef FPMUL_FTZ_EN
            o_man       = {MAN_W{1'b0}};
            o_zero      = 1'b1;
            o_underflow = 1'b1;
            o_inexact   = 1'b1;
`else
            o_underflow = 1'b1;
`endif
          end
        end
      end
      default: begin
        o_sign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fp32_mul_pipe.sv
// Two-stage pipelined binary32 multiplier. Defining FPMUL_FTZ_EN treats subnormal
// inputs as zero and flushes subnormal results; the default build keeps gradual underflow.
module fp32_mul_pipe
  import fp32_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             Sx,
  input  logic [EXP_W-1:0] Ex,
  input  logic [MAN_W-1:0] Mx,
  input  logic             Sy,
  input  logic [EXP_W-1:0] Ey,
  input  logic [MAN_W-1:0] My,
  input  logic [1:0]       R_mode,
  output logic             Sz,
  output logic [EXP_W-1:0] Ez,
  output logic [MAN_W-1:0] Mz,
  output logic             invalid_flagex,
  output logic             overflow_flagex,
  output logic             underflow_flagex,
  output logic             inexact_flagex,
  output logic             zero_flagex
);

  op_class_e         w_cls_x;
  op_class_e         w_cls_y;
  res_kind_e         w_kind;
  logic [23:0]       w_sig_x;
  logic [23:0]       w_sig_y;
  logic [EXP_W-1:0]  w_eff_x;
  logic [EXP_W-1:0]  w_eff_y;
  logic signed [9:0] w_exp_sum;

  logic              r_live;
  res_kind_e         r_kind;
  logic              r_sign;
  logic [47:0]       r_prod;
  logic signed [9:0] r_exp;
  rm_e               r_rm;

  logic              w_sz;
  logic [EXP_W-1:0]  w_ez;
  logic [MAN_W-1:0]  w_mz;
  logic              w_inv;
  logic              w_ovf;
  logic              w_unf;
  logic              w_inx;
  logic              w_zer;

  logic              r_sz;
  logic [EXP_W-1:0]  r_ez;
  logic [MAN_W-1:0]  r_mz;
  logic              r_inv;
  logic              r_ovf;
  logic              r_unf;
  logic              r_inx;
  logic              r_zer;

  // Subnormals carry hidden bit 0 and an effective exponent of 1.
  assign w_cls_x   = classify(Ex, Mx);
  assign w_cls_y   = classify(Ey, My);
  assign w_sig_x   = {(w_cls_x == CLS_NORM), Mx};
  assign w_sig_y   = {(w_cls_y == CLS_NORM), My};
  assign w_eff_x   = (Ex == {EXP_W{1'b0}}) ? 8'd1 : Ex;
  assign w_eff_y   = (Ey == {EXP_W{1'b0}}) ? 8'd1 : Ey;
  assign w_exp_sum = $signed({2'b00, w_eff_x}) + $signed({2'b00, w_eff_y}) - 10'(BIAS);

  // Special-operand resolution in priority order: NaN/0*inf, inf, zero.
  always_comb begin
    w_kind = KIND_FINITE;
    if ((w_cls_x == CLS_NAN) || (w_cls_y == CLS_NAN) ||
        ((w_cls_x == CLS_ZERO) && (w_cls_y == CLS_INF)) ||
        ((w_cls_x == CLS_INF) && (w_cls_y == CLS_ZERO))) begin
      w_kind = KIND_NAN;
    end else if ((w_cls_x == CLS_INF) || (w_cls_y == CLS_INF)) begin
      w_kind = KIND_INF;
    end else if ((w_cls_x == CLS_ZERO) || (w_cls_y == CLS_ZERO)) begin
      w_kind = KIND_ZERO;
    end else begin
      w_kind = KIND_FINITE;
    end
  end

  // Stage 1 registers; r_live keeps outputs at zero until real data reaches stage 2.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_live <= 1'b0;
      r_kind <= KIND_FINITE;
      r_sign <= 1'b0;
      r_prod <= 48'd0;
      r_exp  <= 10'sd0;
      r_rm   <= RM_RNE;
    end else begin
      r_live <= 1'b1;
      r_kind <= w_kind;
      r_sign <= Sx ^ Sy;
      r_prod <= 48'(w_sig_x) * 48'(w_sig_y);
      r_exp  <= w_exp_sum;
      r_rm   <= rm_e'(R_mode);
    end
  end

  fp32_round_norm u_round_norm (
    .i_kind      (r_kind),
    .i_sign      (r_sign),
    .i_prod      (r_prod),
    .i_exp       (r_exp),
    .i_rm        (r_rm),
    .o_sign      (w_sz),
    .o_exp       (w_ez),
    .o_man       (w_mz),
    .o_invalid   (w_inv),
    .o_overflow  (w_ovf),
    .o_underflow (w_unf),
    .o_inexact   (w_inx),
    .o_zero      (w_zer)
  );

  // Stage 2 result and flag registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sz  <= 1'b0;
      r_ez  <= {EXP_W{1'b0}};
      r_mz  <= {MAN_W{1'b0}};
      r_inv <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_inx <= 1'b0;
      r_zer <= 1'b0;
    end else if (r_live) begin
      r_sz  <= w_sz;
      r_ez  <= w_ez;
      r_mz  <= w_mz;
      r_inv <= w_inv;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
      r_inx <= w_inx;
      r_zer <= w_zer;
    end else begin
      r_sz  <= 1'b0;
      r_ez  <= {EXP_W{1'b0}};
      r_mz  <= {MAN_W{1'b0}};
      r_inv <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_inx <= 1'b0;
      r_zer <= 1'b0;
    end
  end

  assign Sz               = r_sz;
  assign Ez               = r_ez;
  assign Mz               = r_mz;
  assign invalid_flagex   = r_inv;
  assign overflow_flagex  = r_ovf;
  assign underflow_flagex = r_unf;
  assign inexact_flagex   = r_inx;
  assign zero_flagex      = r_zer;

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Bench for fp32_mul_pipe: directed cases plus a long random stream checked against
// an exact integer-arithmetic reference of IEEE binary32 multiplication.
module tb_fp32_mul_pipe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Sx, Sy;
  logic [7:0]  Ex, Ey;
  logic [22:0] Mx, My;
  logic [1:0]  R_mode;
  logic        Sz;
  logic [7:0]  Ez;
  logic [22:0] Mz;
  logic        invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex;

  int errors = 0;
  int checks = 0;

  fp32_mul_pipe dut (
    .CLK(CLK), .RST(RST),
    .Sx(Sx), .Ex(Ex), .Mx(Mx), .Sy(Sy), .Ey(Ey), .My(My), .R_mode(R_mode),
    .Sz(Sz), .Ez(Ez), .Mz(Mz),
    .invalid_flagex(invalid_flagex), .overflow_flagex(overflow_flagex),
    .underflow_flagex(underflow_flagex), .inexact_flagex(inexact_flagex),
    .zero_flagex(zero_flagex)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Result word followed by {invalid, overflow, underflow, inexact, zero}.
  function automatic logic [36:0] dut_word();
    return {Sz, Ez, Mz, invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex};
  endfunction

  // Exact product P * 2^q, rounded to the representable quantum by integer division.
  function automatic logic [36:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm);
    logic sx, sy, s, inc, gt, eq, nz, unf, zer;
    int ex, ey, q, msb, quant, k, bexp;
    longint unsigned mx, my, p, n, rem, half;
    bit xn, yn, xi, yi, xz, yz;
    sx = x[31]; ex = int'(x[30:23]); mx = 64'(x[22:0]);
    sy = y[31]; ey = int'(y[30:23]); my = 64'(y[22:0]);
    s  = sx ^ sy;
    xn = (ex == 255) && (mx != 0); xi = (ex == 255) && (mx == 0); xz = (ex == 0) && (mx == 0);
    yn = (ey == 255) && (my != 0); yi = (ey == 255) && (my == 0); yz = (ey == 0) && (my == 0);
    if (xn || yn || (xz && yi) || (xi && yz)) return {32'h7FFFFFFF, 5'b10000};
    if (xi || yi) return {s, 8'hFF, 23'd0, 5'b01000};
    if (xz || yz) return {s, 31'd0, 5'b00001};
    if (ex != 0) mx = mx + (64'd1 << 23); else ex = 1;
    if (ey != 0) my = my + (64'd1 << 23); else ey = 1;
    p = mx * my;
    q = ex + ey - 300;
    msb = 0;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    quant = (msb + q >= -126) ? (msb + q - 23) : -149;
    k = quant - q;
    gt = 1'b0; eq = 1'b0; nz = 1'b0;
    if (k <= 0) begin
      n = p << (-k);
    end else if (k > 60) begin
      n = 64'd0; nz = 1'b1;
    end else begin
      n = p >> k;
      rem = p - (n << k);
      half = 64'd1 << (k - 1);
      gt = rem > half; eq = rem == half; nz = rem != 0;
    end
    case (rm)
      2'b00:   inc = gt || (eq && n[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = nz && !s;
      default: inc = nz && s;
    endcase
    n = n + 64'(inc);
    if (n == (64'd1 << 24)) begin n = 64'd1 << 23; quant = quant + 1; end
    bexp = (n >= (64'd1 << 23)) ? quant + 150 : 0;
    if (bexp >= 255) begin
      if (rm == 2'b00 || (rm == 2'b10 && !s) || (rm == 2'b11 && s))
        return {s, 8'hFF, 23'd0, 5'b01010};
      else
        return {s, 8'hFE, 23'h7FFFFF, 5'b01010};
    end
    zer = (bexp == 0) && (n == 0);
    unf = (bexp == 0) && (n != 0);
    return {s, bexp[7:0], n[22:0], 2'b00, unf, nz, zer};
  endfunction

  // Operands biased toward subnormal, extreme and special exponents.
  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(190, 254));
      3:       e = 8'($urandom_range(1, 70));
      default: e = 8'($urandom_range(1, 254));
    endcase
    m = 23'($urandom);
    if ($urandom_range(0, 15) == 0) m = 23'd0;
    if ($urandom_range(0, 15) == 0) m = 23'h7FFFFF;
    return {1'($urandom), e, m};
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm);
    {Sx, Ex, Mx} = x;
    {Sy, Ey, My} = y;
    R_mode = rm;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm, output logic [36:0] got);
    @(negedge CLK);
    drive(x, y, rm);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    got = dut_word();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    drive(32'h3FC00000, 32'h40000000, 2'b00);
    repeat (3) @(negedge CLK);
    checks++;
    if (dut_word() !== 37'd0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_word(), 37'd0);
    end
    RST = 1'b1;
  endtask

  task automatic test_normal();
    logic [36:0] got;
    run_op(32'h3FC00000, 32'h40000000, 2'b00, got);
    checks++;
    if (got !== {32'h40400000, 5'b00000}) begin errors++; $display("FAIL normal_1p5x2 got=%h exp=%h", got, {32'h40400000, 5'b00000}); end
    run_op(32'h7F800000, 32'hBF800000, 2'b00, got);
    checks++;
    if (got !== {32'hFF800000, 5'b01000}) begin errors++; $display("FAIL inf_x_neg got=%h exp=%h", got, {32'hFF800000, 5'b01000}); end
  endtask

  task automatic test_rounding();
    logic [36:0] got;
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b00, got);
    checks++;
    if (got !== {32'h407FFFFE, 5'b00010}) begin errors++; $display("FAIL round_rne got=%h exp=%h", got, {32'h407FFFFE, 5'b00010}); end
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b01, got);
    checks++;
    if (got !== {32'h407FFFFE, 5'b00010}) begin errors++; $display("FAIL round_rtz got=%h exp=%h", got, {32'h407FFFFE, 5'b00010}); end
    run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b10, got);
    checks++;
    if (got !== {32'h407FFFFF, 5'b00010}) begin errors++; $display("FAIL round_rup got=%h exp=%h", got, {32'h407FFFFF, 5'b00010}); end
    run_op(32'h3FFFFFFF, 32'hBFFFFFFF, 2'b11, got);
    checks++;
    if (got !== {32'hC07FFFFF, 5'b00010}) begin errors++; $display("FAIL round_rdn got=%h exp=%h", got, {32'hC07FFFFF, 5'b00010}); end
  endtask

  task automatic test_overflow();
    logic [36:0] got;
    run_op(32'h7F7FFFFF, 32'h40000000, 2'b00, got);
    checks++;
    if (got !== {32'h7F800000, 5'b01010}) begin errors++; $display("FAIL ovf_rne got=%h exp=%h", got, {32'h7F800000, 5'b01010}); end
    run_op(32'h7F7FFFFF, 32'h40000000, 2'b01, got);
    checks++;
    if (got !== {32'h7F7FFFFF, 5'b01010}) begin errors++; $display("FAIL ovf_rtz got=%h exp=%h", got, {32'h7F7FFFFF, 5'b01010}); end
    run_op(32'hFF7FFFFF, 32'h40000000, 2'b10, got);
    checks++;
    if (got !== {32'hFF7FFFFF, 5'b01010}) begin errors++; $display("FAIL ovf_rup_neg got=%h exp=%h", got, {32'hFF7FFFFF, 5'b01010}); end
  endtask

  task automatic test_underflow_zero();
    logic [36:0] got;
    run_op(32'h00800000, 32'h3F000000, 2'b00, got);
    checks++;
    if (got !== {32'h00400000, 5'b00100}) begin errors++; $display("FAIL subnormal_exact got=%h exp=%h", got, {32'h00400000, 5'b00100}); end
    run_op(32'h80000000, 32'h3F800000, 2'b00, got);
    checks++;
    if (got !== {32'h80000000, 5'b00001}) begin errors++; $display("FAIL neg_zero got=%h exp=%h", got, {32'h80000000, 5'b00001}); end
    run_op(32'h00FFFFFF, 32'h3F000000, 2'b00, got);
    checks++;
    if (got !== {32'h00800000, 5'b00010}) begin errors++; $display("FAIL sub_to_minnorm got=%h exp=%h", got, {32'h00800000, 5'b00010}); end
    run_op(32'h00000001, 32'h00000001, 2'b00, got);
    checks++;
    if (got !== {32'h00000000, 5'b00011}) begin errors++; $display("FAIL round_to_zero got=%h exp=%h", got, {32'h00000000, 5'b00011}); end
    run_op(32'h00000001, 32'h00000001, 2'b10, got);
    checks++;
    if (got !== {32'h00000001, 5'b00110}) begin errors++; $display("FAIL min_sub_rup got=%h exp=%h", got, {32'h00000001, 5'b00110}); end
  endtask

  task automatic test_invalid();
    logic [36:0] got;
    run_op(32'h00000000, 32'h7F800000, 2'b00, got);
    checks++;
    if (got !== {32'h7FFFFFFF, 5'b10000}) begin errors++; $display("FAIL zero_x_inf got=%h exp=%h", got, {32'h7FFFFFFF, 5'b10000}); end
    run_op(32'h7FC00000, 32'h3F800000, 2'b00, got);
    checks++;
    if (got !== {32'h7FFFFFFF, 5'b10000}) begin errors++; $display("FAIL nan_operand got=%h exp=%h", got, {32'h7FFFFFFF, 5'b10000}); end
  endtask

  task automatic test_back_to_back(input int n);
    logic [36:0] q[$];
    logic [36:0] e, got;
    logic [31:0] x, y;
    logic [1:0]  rm;
    int shown = 0;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge CLK);
      if (q.size() == 2 || (i >= n && q.size() > 0)) begin
        e = q.pop_front();
        got = dut_word();
        checks++;
        if (got !== e) begin
          errors++;
          if (shown < 10) $display("FAIL stream cycle=%0d got=%h exp=%h", i, got, e);
          shown++;
        end
      end
      if (i < n) begin
        x = rand_op(); y = rand_op(); rm = 2'($urandom);
        drive(x, y, rm);
        q.push_back(ref_mul(x, y, rm));
      end
    end
  endtask

  task automatic test_reset_midstream();
    repeat (3) begin
      @(negedge CLK);
      drive(32'h3FC00000, 32'h40000000, 2'b00);
    end
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (dut_word() !== 37'd0) begin errors++; $display("FAIL reset_async got=%h exp=%h", dut_word(), 37'd0); end
    @(negedge CLK);
    RST = 1'b1;
    drive(32'h3FC00000, 32'h40000000, 2'b00);
    @(posedge CLK);
    #1;
    checks++;
    if (dut_word() !== 37'd0) begin errors++; $display("FAIL refill_zero got=%h exp=%h", dut_word(), 37'd0); end
    @(posedge CLK);
    #1;
    checks++;
    if (dut_word() !== {32'h40400000, 5'b00000}) begin
      errors++; $display("FAIL refill_first got=%h exp=%h", dut_word(), {32'h40400000, 5'b00000});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_rounding();
    test_overflow();
    test_underflow_zero();
    test_invalid();
    test_back_to_back(15000);
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
